// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scan, row sync, hex decode and two-digit shift register
module keypad_scanner #(
  parameter int SCAN_TICKS  = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_raw,
  input  logic       button_pressed,
  input  logic       new_hex,
  input  logic [3:0] pressed_row,
  output logic [3:0] col,
  output logic [3:0] q_row_keys,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       key_valid
);
  localparam int CW = $clog2(SCAN_TICKS);
  localparam logic [CW-1:0] LAST = CW'(SCAN_TICKS - 1);
  // Hex value per {row, col} index, nibble 0 = r0c0 ('1') up to nibble 15 = r3c3 ('D')
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic {SCAN, LOCK} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0] col_nx;
  logic [3:0] sync_q [SYNC_STAGES];
  logic accept;
  logic [1:0] r, c;
  // Row lines are asynchronous to clk: pass them through a flop chain
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    else begin
      sync_q[0] <= row_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  assign q_row_keys = sync_q[SYNC_STAGES-1];
  // Scan FSM state, dwell counter and column drive
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= SCAN;
      cnt   <= '0;
      col   <= 4'b0001;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      col   <= col_nx;
    end
  // Rotate only while no row is seen and the debouncer is idle, so the column stays put during its IDLE->WAIT step
  always_comb begin
    state_nx = button_pressed ? LOCK : SCAN;
    cnt_nx   = cnt;
    col_nx   = col;
    if (state == LOCK) cnt_nx = '0;
    else if (q_row_keys == 4'b0000 && !button_pressed) begin
      cnt_nx = (cnt == LAST) ? '0 : cnt + 1'b1;
      col_nx = (cnt == LAST) ? {col[2:0], col[3]} : col;
    end
  end
  assign accept = new_hex && pressed_row != 4'b0000 && (pressed_row & (pressed_row - 4'd1)) == 4'b0000;
  assign r = {pressed_row[3] | pressed_row[2], pressed_row[3] | pressed_row[1]};
  assign c = {col[3] | col[2], col[3] | col[1]};
  // Shift an accepted key into the display register; malformed row patterns are dropped
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      digit_new <= '0;
      digit_old <= '0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        digit_old <= digit_new;
        digit_new <= KEY_MAP[{r, c, 2'b00} +: 4];
      end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed self-checking bench for keypad_scanner
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] row_raw = '0;
  logic button_pressed = 1'b0;
  logic new_hex = 1'b0;
  logic [3:0] pressed_row = '0;
  logic [3:0] col, q_row_keys, digit_new, digit_old;
  logic key_valid;
  int checks = 0;
  int errors = 0;
  int kv_count = 0;

  keypad_scanner #(.SCAN_TICKS(5), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .row_raw(row_raw), .button_pressed(button_pressed),
    .new_hex(new_hex), .pressed_row(pressed_row), .col(col), .q_row_keys(q_row_keys),
    .digit_new(digit_new), .digit_old(digit_old), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // Count cycles in which key_valid was high
  always @(posedge clk) if (key_valid === 1'b1) kv_count <= kv_count + 1;

  // Wait for a fresh arrival of column t (dwell counter at 0)
  task automatic wait_col(input logic [3:0] t);
    int n = 0;
    while (col === t && n < 40) begin @(negedge clk); n++; end
    while (col !== t && n < 40) begin @(negedge clk); n++; end
    if (col !== t) begin
      checks++; errors++;
      $display("FAIL wait_col: col=%b, required %b within 40 clks", col, t);
    end
  endtask

  // Press a key through the debouncer handshake and check the resulting digits
  task automatic press(input logic [3:0] c, input logic [3:0] r, input logic [3:0] exp_new,
                       input logic [3:0] exp_old, input bit release_key, input string name);
    wait_col(c);
    row_raw = r;
    repeat (2) @(negedge clk);
    checks++;
    if (q_row_keys !== r) begin errors++; $display("FAIL %s sync: q_row_keys=%b, required %b", name, q_row_keys, r); end
    button_pressed = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (col !== c) begin errors++; $display("FAIL %s lock col: col=%b, required %b", name, col, c); end
    new_hex = 1'b1;
    pressed_row = r;
    @(negedge clk);
    new_hex = 1'b0;
    pressed_row = '0;
    checks++;
    if ({digit_old, digit_new, key_valid} !== {exp_old, exp_new, 1'b1}) begin
      errors++;
      $display("FAIL %s shift: old/new/kv=%h/%h/%b, required %h/%h/1", name, digit_old, digit_new, key_valid, exp_old, exp_new);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({col, digit_old, digit_new, key_valid} !== {c, exp_old, exp_new, 1'b0}) begin
      errors++;
      $display("FAIL %s hold: col=%b old/new/kv=%h/%h/%b, required %b %h/%h/0", name, col, digit_old, digit_new, key_valid, c, exp_old, exp_new);
    end
    if (release_key) begin
      row_raw = '0;
      button_pressed = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [3:0] seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] prev = 4'b0001;
    repeat (2) @(negedge clk);
    checks++;
    if ({col, digit_old, digit_new, key_valid, q_row_keys} !== {4'b0001, 8'h00, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL reset: col=%b old/new=%h/%h kv=%b q=%b, required 0001 0/0 0 0000", col, digit_old, digit_new, key_valid, q_row_keys);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      checks++;
      if (col !== prev) begin errors++; $display("FAIL scan dwell %0d: col=%b, required %b", i, col, prev); end
      @(negedge clk);
      checks++;
      if (col !== seq[i]) begin errors++; $display("FAIL scan step %0d: col=%b, required %b", i, col, seq[i]); end
      prev = seq[i];
    end
  endtask

  task automatic test_single_key;
    int k0 = kv_count;
    press(4'b0010, 4'b0010, 4'h5, 4'h0, 1'b1, "key5");
    checks++;
    if (kv_count - k0 !== 1) begin errors++; $display("FAIL key5 pulses: count=%0d, required 1", kv_count - k0); end
  endtask

  task automatic test_two_keys;
    int k0 = kv_count;
    press(4'b0100, 4'b0001, 4'h3, 4'h5, 1'b1, "key3");
    press(4'b1000, 4'b0001, 4'hA, 4'h3, 1'b1, "keyA");
    checks++;
    if (kv_count - k0 !== 2) begin errors++; $display("FAIL two_keys pulses: count=%0d, required 2", kv_count - k0); end
  endtask

  task automatic test_invalid_rows;
    logic [3:0] bad [2] = '{4'b0011, 4'b0000};
    for (int i = 0; i < 2; i++) begin
      new_hex = 1'b1;
      pressed_row = bad[i];
      @(negedge clk);
      new_hex = 1'b0;
      pressed_row = '0;
      checks++;
      if ({digit_old, digit_new, key_valid} !== {4'h3, 4'hA, 1'b0}) begin
        errors++;
        $display("FAIL invalid row %b: old/new/kv=%h/%h/%b, required 3/A/0", bad[i], digit_old, digit_new, key_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    wait_col(4'b0001);
    button_pressed = 1'b1;
    new_hex = 1'b1;
    pressed_row = 4'b0001;
    @(negedge clk);
    checks++;
    if ({digit_old, digit_new, key_valid} !== {4'hA, 4'h1, 1'b1}) begin
      errors++;
      $display("FAIL b2b first: old/new/kv=%h/%h/%b, required A/1/1", digit_old, digit_new, key_valid);
    end
    pressed_row = 4'b0100;
    @(negedge clk);
    new_hex = 1'b0;
    pressed_row = '0;
    checks++;
    if ({digit_old, digit_new, key_valid} !== {4'h1, 4'h7, 1'b1}) begin
      errors++;
      $display("FAIL b2b second: old/new/kv=%h/%h/%b, required 1/7/1", digit_old, digit_new, key_valid);
    end
    @(negedge clk);
    checks++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL b2b pulse end: key_valid=%b, required 0", key_valid); end
    button_pressed = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_terminal_count;
    wait_col(4'b1000);
    repeat (2) @(negedge clk);
    row_raw = 4'b0010;
    repeat (3) @(negedge clk);
    checks++;
    if (col !== 4'b1000) begin errors++; $display("FAIL terminal hold: col=%b, required 1000", col); end
    repeat (5) @(negedge clk);
    checks++;
    if (col !== 4'b1000) begin errors++; $display("FAIL terminal held row: col=%b, required 1000", col); end
    button_pressed = 1'b1;
    @(negedge clk);
    new_hex = 1'b1;
    pressed_row = 4'b0010;
    @(negedge clk);
    new_hex = 1'b0;
    pressed_row = '0;
    checks++;
    if ({digit_old, digit_new, key_valid} !== {4'h7, 4'hB, 1'b1}) begin
      errors++;
      $display("FAIL terminal decode: old/new/kv=%h/%h/%b, required 7/B/1", digit_old, digit_new, key_valid);
    end
    row_raw = '0;
    button_pressed = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_in_lock;
    press(4'b0010, 4'b0010, 4'h5, 4'hB, 1'b1, "key5b");
    press(4'b1000, 4'b0001, 4'hA, 4'h5, 1'b0, "keyA_held");
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({col, digit_old, digit_new, key_valid, q_row_keys} !== {4'b0001, 8'h00, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL async reset: col=%b old/new=%h/%h kv=%b q=%b, required 0001 0/0 0 0000", col, digit_old, digit_new, key_valid, q_row_keys);
    end
    row_raw = '0;
    button_pressed = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (col !== 4'b0001) begin errors++; $display("FAIL restart dwell: col=%b, required 0001", col); end
    @(negedge clk);
    checks++;
    if (col !== 4'b0010) begin errors++; $display("FAIL restart step: col=%b, required 0010", col); end
  endtask

  initial begin
    test_reset;
    test_single_key;
    test_two_keys;
    test_invalid_rows;
    test_back_to_back;
    test_terminal_count;
    test_reset_in_lock;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
